// File: rtl/cache_fill_writer.sv
// cache_fill_writer: miss-fill write side of the L2 lookup path.
// Picks a victim way (lowest invalid, else tree pseudo-LRU), writes back a
// dirty victim through a valid/ready handshake, then installs the new tag
// and line. Owns per-set valid, dirty and PLRU state.
module cache_fill_writer #(
    parameter int WAYS       = 8,
    parameter int TAG_BITS   = 10,
    parameter int DATA_BITS  = 9,
    parameter int INDEX_BITS = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     fill_req,
    input  logic [INDEX_BITS-1:0]    fill_index,
    input  logic [TAG_BITS-1:0]      fill_tag,
    input  logic [DATA_BITS-1:0]     fill_data,
    input  logic                     fill_dirty,
    output logic                     fill_ack,
    output logic [$clog2(WAYS)-1:0]  fill_way,
    input  logic                     hit_valid,
    input  logic [INDEX_BITS-1:0]    hit_index,
    input  logic [$clog2(WAYS)-1:0]  hit_way,
    input  logic [INDEX_BITS-1:0]    valid_rd_index,
    output logic [WAYS-1:0]          valid_out,
    output logic                     arr_rd_en,
    output logic [INDEX_BITS-1:0]    arr_rd_index,
    output logic [$clog2(WAYS)-1:0]  arr_rd_way,
    input  logic [TAG_BITS-1:0]      arr_rd_tag,
    input  logic [DATA_BITS-1:0]     arr_rd_data,
    output logic                     wb_valid,
    input  logic                     wb_ready,
    output logic [INDEX_BITS-1:0]    wb_index,
    output logic [TAG_BITS-1:0]      wb_tag,
    output logic [DATA_BITS-1:0]     wb_data,
    output logic                     arr_wr_en,
    output logic [INDEX_BITS-1:0]    arr_wr_index,
    output logic [$clog2(WAYS)-1:0]  arr_wr_way,
    output logic [TAG_BITS-1:0]      arr_wr_tag,
    output logic [DATA_BITS-1:0]     arr_wr_data
);

    localparam int WAY_W = $clog2(WAYS);
    localparam int SETS  = 2 ** INDEX_BITS;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        RDWAIT,
        WRITEBACK,
        WRITE
    } state_t;

    state_t state, state_next;

    // Latched fill request
    logic [INDEX_BITS-1:0] req_index;
    logic [TAG_BITS-1:0]   req_tag;
    logic [DATA_BITS-1:0]  req_data;
    logic                  req_dirty;

    // Victim chosen in SELECT, used by WRITE
    logic [WAY_W-1:0]      vic_way;

    // Per-set state; PLRU is a heap-ordered tree, node 0 = root,
    // children of node n are 2n+1 (lower half) and 2n+2 (upper half).
    logic [WAYS-1:0]       valid_q [SETS];
    logic [WAYS-1:0]       dirty_q [SETS];
    logic [WAYS-2:0]       plru_q  [SETS];

    logic                  hit_same;
    logic [WAYS-2:0]       hit_plru_next;
    logic [WAYS-2:0]       sel_plru;
    logic [WAYS-2:0]       wr_plru_next;
    logic [WAY_W-1:0]      sel_way;
    logic                  sel_evict;

    // Touch: walk from the leaf of 'way' up to the root, making every node
    // on the path point at the sibling subtree.
    function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] bits,
                                                   input logic [WAY_W-1:0] way);
        logic [WAYS-2:0] r;
        int idx;
        int par;
        r   = bits;
        idx = int'(way) + WAYS - 1;
        for (int l = 0; l < WAY_W; l++) begin
            par    = (idx - 1) / 2;
            // Odd heap index = lower child, so point the parent upward.
            r[par] = (idx % 2) == 1;
            idx    = par;
        end
        return r;
    endfunction

    // Victim: follow the node bits from the root down to a leaf.
    function automatic logic [WAY_W-1:0] plru_victim(input logic [WAYS-2:0] bits);
        int node;
        node = 0;
        for (int l = 0; l < WAY_W; l++) begin
            node = 2 * node + 1 + int'(bits[node]);
        end
        return WAY_W'(node - (WAYS - 1));
    endfunction

    // A same-cycle hit to the set being filled is forwarded so that both the
    // victim choice in SELECT and the fill touch in WRITE see it (hit first).
    assign hit_same      = hit_valid && (hit_index == req_index);
    assign hit_plru_next = plru_touch(plru_q[hit_index], hit_way);
    assign sel_plru      = hit_same ? hit_plru_next : plru_q[req_index];
    assign wr_plru_next  = plru_touch(sel_plru, vic_way);

    // Victim select: lowest-numbered invalid way, else the PLRU way.
    always_comb begin
        sel_way = plru_victim(sel_plru);
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (!valid_q[req_index][i]) begin
                sel_way = WAY_W'(i);
            end
        end
        sel_evict = valid_q[req_index][sel_way] && dirty_q[req_index][sel_way];
    end

    // Next-state and strobe decode.
    always_comb begin
        state_next = state;
        arr_rd_en  = 1'b0;
        wb_valid   = 1'b0;
        arr_wr_en  = 1'b0;
        fill_ack   = 1'b0;
        case (state)
            IDLE: begin
                if (fill_req) begin
                    state_next = SELECT;
                end
            end
            SELECT: begin
                if (sel_evict) begin
                    arr_rd_en  = 1'b1;
                    state_next = RDWAIT;
                end else begin
                    state_next = WRITE;
                end
            end
            RDWAIT: begin
                state_next = WRITEBACK;
            end
            WRITEBACK: begin
                wb_valid = 1'b1;
                if (wb_ready) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                arr_wr_en  = 1'b1;
                fill_ack   = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign arr_rd_index = req_index;
    assign arr_rd_way   = sel_way;
    assign arr_wr_index = req_index;
    assign arr_wr_way   = vic_way;
    assign arr_wr_tag   = req_tag;
    assign arr_wr_data  = req_data;
    assign fill_way     = vic_way;
    assign valid_out    = valid_q[valid_rd_index];

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Capture the fill request when it is accepted in IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_index <= '0;
            req_tag   <= '0;
            req_data  <= '0;
            req_dirty <= 1'b0;
        end else if (state == IDLE && fill_req) begin
            req_index <= fill_index;
            req_tag   <= fill_tag;
            req_data  <= fill_data;
            req_dirty <= fill_dirty;
        end
    end

    // Hold the victim way from SELECT through WRITE.
    always_ff @(posedge clk) begin
        if (reset) begin
            vic_way <= '0;
        end else if (state == SELECT) begin
            vic_way <= sel_way;
        end
    end

    // Register the victim line returned by the array for the writeback offer.
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_index <= '0;
            wb_tag   <= '0;
            wb_data  <= '0;
        end else if (state == RDWAIT) begin
            wb_index <= req_index;
            wb_tag   <= arr_rd_tag;
            wb_data  <= arr_rd_data;
        end
    end

    // Valid/dirty update on commit; hits never change these bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
            end
        end else if (state == WRITE) begin
            valid_q[req_index][vic_way] <= 1'b1;
            dirty_q[req_index][vic_way] <= req_dirty;
        end
    end

    // PLRU update; the later fill write overrides the hit write on the same
    // set, and already contains the hit touch through sel_plru.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < SETS; s++) begin
                plru_q[s] <= '0;
            end
        end else begin
            if (hit_valid) begin
                plru_q[hit_index] <= hit_plru_next;
            end
            if (state == WRITE) begin
                plru_q[req_index] <= wr_plru_next;
            end
        end
    end

endmodule

// File: tb/tb_cache_fill_writer.sv
// Self-checking bench for cache_fill_writer: directed scenarios plus a
// randomized phase checked against a set-level behavioural cache model.
module tb_cache_fill_writer;

    localparam int WAYS = 8;
    localparam int TB   = 10;
    localparam int DB   = 9;
    localparam int IB   = 4;
    localparam int SETS = 16;

    logic          clk;
    logic          reset;
    logic          fill_req;
    logic [IB-1:0] fill_index;
    logic [TB-1:0] fill_tag;
    logic [DB-1:0] fill_data;
    logic          fill_dirty;
    logic          fill_ack;
    logic [2:0]    fill_way;
    logic          hit_valid;
    logic [IB-1:0] hit_index;
    logic [2:0]    hit_way;
    logic [IB-1:0] valid_rd_index;
    logic [WAYS-1:0] valid_out;
    logic          arr_rd_en;
    logic [IB-1:0] arr_rd_index;
    logic [2:0]    arr_rd_way;
    logic [TB-1:0] arr_rd_tag;
    logic [DB-1:0] arr_rd_data;
    logic          wb_valid;
    logic          wb_ready;
    logic [IB-1:0] wb_index;
    logic [TB-1:0] wb_tag;
    logic [DB-1:0] wb_data;
    logic          arr_wr_en;
    logic [IB-1:0] arr_wr_index;
    logic [2:0]    arr_wr_way;
    logic [TB-1:0] arr_wr_tag;
    logic [DB-1:0] arr_wr_data;

    cache_fill_writer #(.WAYS(WAYS), .TAG_BITS(TB), .DATA_BITS(DB), .INDEX_BITS(IB)) dut (
        .clk(clk), .reset(reset),
        .fill_req(fill_req), .fill_index(fill_index), .fill_tag(fill_tag),
        .fill_data(fill_data), .fill_dirty(fill_dirty),
        .fill_ack(fill_ack), .fill_way(fill_way),
        .hit_valid(hit_valid), .hit_index(hit_index), .hit_way(hit_way),
        .valid_rd_index(valid_rd_index), .valid_out(valid_out),
        .arr_rd_en(arr_rd_en), .arr_rd_index(arr_rd_index), .arr_rd_way(arr_rd_way),
        .arr_rd_tag(arr_rd_tag), .arr_rd_data(arr_rd_data),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_index(wb_index),
        .wb_tag(wb_tag), .wb_data(wb_data),
        .arr_wr_en(arr_wr_en), .arr_wr_index(arr_wr_index), .arr_wr_way(arr_wr_way),
        .arr_wr_tag(arr_wr_tag), .arr_wr_data(arr_wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External tag/data arrays: one-cycle read latency, written by the DUT.
    logic [TB-1:0] a_tag  [SETS][WAYS];
    logic [DB-1:0] a_data [SETS][WAYS];
    always @(posedge clk) begin
        if (arr_rd_en) begin
            arr_rd_tag  <= a_tag[arr_rd_index][arr_rd_way];
            arr_rd_data <= a_data[arr_rd_index][arr_rd_way];
        end
        if (arr_wr_en) begin
            a_tag[arr_wr_index][arr_wr_way]  <= arr_wr_tag;
            a_data[arr_wr_index][arr_wr_way] <= arr_wr_data;
        end
    end

    // Behavioural cache model
    bit m_valid [SETS][WAYS];
    bit m_dirty [SETS][WAYS];
    bit m_plru  [SETS][WAYS-1];
    int m_tag   [SETS][WAYS];
    int m_data  [SETS][WAYS];

    int total;
    int passed;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic m_clear();
        for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
            end
            for (int n = 0; n < WAYS - 1; n++) m_plru[s][n] = 1'b0;
        end
    endtask

    // Top-down over halving intervals: each node on the way's path is
    // pointed to the half that does not contain it.
    task automatic m_touch(input int s, input int w);
        int lo, n, node;
        lo = 0; n = WAYS; node = 0;
        while (n > 1) begin
            n = n / 2;
            if (w >= lo + n) begin
                m_plru[s][node] = 1'b0;
                lo = lo + n;
                node = 2 * node + 2;
            end else begin
                m_plru[s][node] = 1'b1;
                node = 2 * node + 1;
            end
        end
    endtask

    function automatic int m_victim(input int s);
        int lo, n, node;
        for (int w = 0; w < WAYS; w++) if (!m_valid[s][w]) return w;
        lo = 0; n = WAYS; node = 0;
        while (n > 1) begin
            n = n / 2;
            if (m_plru[s][node]) begin
                lo = lo + n;
                node = 2 * node + 2;
            end else begin
                node = 2 * node + 1;
            end
        end
        return lo;
    endfunction

    function automatic int m_vec(input int s);
        int v;
        v = 0;
        for (int w = 0; w < WAYS; w++) if (m_valid[s][w]) v = v | (1 << w);
        return v;
    endfunction

    task automatic m_install(input int s, input int v, input int tg, input int dt, input bit dty);
        m_valid[s][v] = 1'b1;
        m_dirty[s][v] = dty;
        m_tag[s][v]   = tg;
        m_data[s][v]  = dt;
        m_touch(s, v);
    endtask

    task automatic chk_valid(input int s);
        valid_rd_index = IB'(s);
        #1;
        chk($sformatf("valid_out[%0d]", s), int'(valid_out), m_vec(s));
    endtask

    task automatic idle_hit(input int s, input int w);
        @(negedge clk);
        hit_valid = 1'b1; hit_index = IB'(s); hit_way = 3'(w);
        m_touch(s, w);
        @(negedge clk);
        hit_valid = 1'b0;
    endtask

    // One complete fill. hphase: 0 none, 1 hit during SELECT, 2 hit during
    // WRITE. abort: assert reset in the last WRITEBACK cycle instead of ready.
    task automatic do_fill(input int s, input int tg, input int dt, input bit dty,
                           input int hold, input int hphase, input int hs,
                           input int hw, input bit abort);
        int  v;
        bit  wb;
        @(negedge clk);
        fill_req = 1'b1; fill_index = IB'(s); fill_tag = TB'(tg);
        fill_data = DB'(dt); fill_dirty = dty;
        @(negedge clk);
        if (hphase == 1) begin
            hit_valid = 1'b1; hit_index = IB'(hs); hit_way = 3'(hw);
            m_touch(hs, hw);
        end
        #1;
        v  = m_victim(s);
        wb = m_valid[s][v] && m_dirty[s][v];
        chk("rd_en", int'(arr_rd_en), int'(wb));
        if (wb) begin
            chk("rd_way", int'(arr_rd_way), v);
            chk("rd_index", int'(arr_rd_index), s);
        end
        chk("ack_select", int'(fill_ack), 0);
        @(negedge clk);
        hit_valid = 1'b0;
        if (wb) begin
            chk("wb_rdwait", int'(wb_valid), 0);
            for (int i = 0; i <= hold; i++) begin
                @(negedge clk);
                chk("wb_valid", int'(wb_valid), 1);
                chk("wb_tag", int'(wb_tag), m_tag[s][v]);
                chk("wb_data", int'(wb_data), m_data[s][v]);
                chk("wb_index", int'(wb_index), s);
                chk("wr_en_wb", int'(arr_wr_en), 0);
                if (i == hold) begin
                    if (abort) reset = 1'b1;
                    else wb_ready = 1'b1;
                end
            end
            @(negedge clk);
            wb_ready = 1'b0;
            if (abort) begin
                chk("abort_wb_valid", int'(wb_valid), 0);
                chk("abort_wr_en", int'(arr_wr_en), 0);
                chk("abort_ack", int'(fill_ack), 0);
                fill_req = 1'b0;
                reset = 1'b0;
                m_clear();
                return;
            end
        end
        if (hphase == 2) begin
            hit_valid = 1'b1; hit_index = IB'(hs); hit_way = 3'(hw);
            m_touch(hs, hw);
        end
        #1;
        chk("fill_ack", int'(fill_ack), 1);
        chk("fill_way", int'(fill_way), v);
        chk("wr_en", int'(arr_wr_en), 1);
        chk("wr_way", int'(arr_wr_way), v);
        chk("wr_index", int'(arr_wr_index), s);
        chk("wr_tag", int'(arr_wr_tag), tg);
        chk("wr_data", int'(arr_wr_data), dt);
        fill_req = 1'b0;
        m_install(s, v, tg, dt, dty);
        @(negedge clk);
        hit_valid = 1'b0;
        chk("ack_idle", int'(fill_ack), 0);
    endtask

    initial begin
        int acks;
        total = 0; passed = 0;
        reset = 1'b1; fill_req = 1'b0; fill_index = '0; fill_tag = '0;
        fill_data = '0; fill_dirty = 1'b0; hit_valid = 1'b0; hit_index = '0;
        hit_way = '0; valid_rd_index = '0; wb_ready = 1'b0;
        m_clear();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ack", int'(fill_ack), 0);
        chk("rst_wr_en", int'(arr_wr_en), 0);
        chk("rst_rd_en", int'(arr_rd_en), 0);
        chk("rst_wb_valid", int'(wb_valid), 0);
        chk("rst_wb_tag", int'(wb_tag), 0);
        chk("rst_fill_way", int'(fill_way), 0);
        chk_valid(3);

        // Invalid-first fills of set 3
        for (int i = 0; i < 8; i++) begin
            do_fill(3, i + 1, int'($urandom_range(0, 511)), 1'b0, 0, 0, 0, 0, 1'b0);
            chk("inorder_way", int'(fill_way), i);
        end
        chk_valid(3);

        // PLRU steering by hits
        for (int w = 0; w < 4; w++) idle_hit(3, w);
        do_fill(3, 9'h100, 9'h011, 1'b0, 0, 0, 0, 0, 1'b0);
        for (int w = 4; w < 8; w++) idle_hit(3, w);
        do_fill(3, 9'h101, 9'h022, 1'b0, 0, 0, 0, 0, 1'b0);

        // Dirty victim with a stalled writeback sink, plus hit during WRITE
        do_fill(5, 10'h155, 9'h1AA, 1'b1, 0, 0, 0, 0, 1'b0);
        for (int w = 1; w < 8; w++)
            do_fill(5, 10'h010 + w, w * 3, 1'b0, 0, 0, 0, 0, 1'b0);
        do_fill(5, 10'h2AB, 9'h0CD, 1'b0, 4, 2, 5, 4, 1'b0);
        do_fill(5, 10'h077, 9'h066, 1'b1, 0, 0, 0, 0, 1'b0);
        // Hit during SELECT to the set being filled (forwarded PLRU)
        do_fill(5, 10'h078, 9'h067, 1'b1, 1, 1, 5, int'($urandom_range(0, 7)), 1'b0);
        chk_valid(5);

        // Steer set 5 to a dirty victim, then reset in WRITEBACK
        for (int k = 0; k < 16; k++) begin
            if (!(m_valid[5][m_victim(5)] && m_dirty[5][m_victim(5)]))
                do_fill(5, int'($urandom_range(0, 1023)), int'($urandom_range(0, 511)),
                        1'b1, 0, 0, 0, 0, 1'b0);
        end
        do_fill(5, 10'h3FF, 9'h1FF, 1'b0, 2, 0, 0, 0, 1'b1);
        for (int s = 0; s < SETS; s++) chk_valid(s);
        repeat (3) begin
            @(negedge clk);
            chk("post_abort_wr_en", int'(arr_wr_en), 0);
        end

        // fill_req held one cycle past the ack: one extra fill is accepted
        @(negedge clk);
        fill_req = 1'b1; fill_index = 4'd9; fill_tag = 10'h0AB;
        fill_data = 9'h0CD; fill_dirty = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("held_ack1", int'(fill_ack), 1);
        chk("held_way1", int'(fill_way), m_victim(9));
        m_install(9, m_victim(9), 10'h0AB, 9'h0CD, 1'b0);
        @(negedge clk);
        chk("held_idle", int'(fill_ack), 0);
        @(negedge clk);
        fill_req = 1'b0;
        acks = 0;
        repeat (6) begin
            @(negedge clk);
            if (fill_ack) begin
                acks++;
                chk("held_way2", int'(fill_way), m_victim(9));
            end
        end
        chk("held_acks", acks, 1);
        m_install(9, m_victim(9), 10'h0AB, 9'h0CD, 1'b0);
        chk_valid(9);

        // Randomized fills and hits over two sets
        for (int n = 0; n < 60; n++) begin
            int s;
            s = int'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0)
                idle_hit(int'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
            do_fill(s, int'($urandom_range(0, 1023)), int'($urandom_range(0, 511)),
                    1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 2)), int'($urandom_range(0, 1)),
                    int'($urandom_range(0, 7)), 1'b0);
            chk_valid(s);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/cache_fill_writer.md
Name: cache_fill_writer

Overview:
- Write side of the L2 set-associative lookup path. On a miss it picks a victim way per set: the lowest invalid way, otherwise the tree pseudo-LRU way.
- If the victim is dirty it reads the victim and issues a writeback handshake. It then writes the new tag and line into the external tag/data arrays.
- Owns the per-set valid, dirty and PLRU state. Exports the valid vector that the hit detector consumes, and accepts hit notifications to keep PLRU current.

Parameters:
WAYS, 8, associativity; power of 2, minimum 2
TAG_BITS, 10, tag width
DATA_BITS, 9, line payload width
INDEX_BITS, 4, set index width (2**INDEX_BITS sets)

Ports:
clk  input  1  single clock, rising edge
reset  input  1  synchronous, active-high
fill_req  input  1  miss fill request; held until fill_ack
fill_index  input  INDEX_BITS  set to fill
fill_tag  input  TAG_BITS  new tag
fill_data  input  DATA_BITS  new line
fill_dirty  input  1  install line as dirty (write-allocate store)
fill_ack  output  1  one-cycle pulse when the fill is committed
fill_way  output  log2(WAYS)  way written; valid while fill_ack=1
hit_valid  input  1  a hit occurred this cycle
hit_index  input  INDEX_BITS  set of the hit
hit_way  input  log2(WAYS)  way that hit
valid_rd_index  input  INDEX_BITS  set whose valid bits are requested
valid_out  output  WAYS  combinational valid vector of valid_rd_index
arr_rd_en  output  1  victim read strobe; array returns data 1 cycle later
arr_rd_index  output  INDEX_BITS  victim set
arr_rd_way  output  log2(WAYS)  victim way
arr_rd_tag  input  TAG_BITS  victim tag (cycle after arr_rd_en)
arr_rd_data  input  DATA_BITS  victim line (cycle after arr_rd_en)
wb_valid  output  1  writeback offer
wb_ready  input  1  writeback sink accepts
wb_index  output  INDEX_BITS  evicted set
wb_tag  output  TAG_BITS  evicted tag
wb_data  output  DATA_BITS  evicted line
arr_wr_en  output  1  array write strobe
arr_wr_index  output  INDEX_BITS  write set
arr_wr_way  output  log2(WAYS)  write way
arr_wr_tag  output  TAG_BITS  write tag
arr_wr_data  output  DATA_BITS  write line

Behaviour:
- Reset: state IDLE. All valid, dirty and PLRU bits cleared. Every registered output is 0. Reset mid-operation aborts the fill with no array write and drops wb_valid in the next cycle.
- States: IDLE, SELECT, RDWAIT, WRITEBACK, WRITE.
- IDLE: when fill_req=1, latch index, tag, data and dirty, then go to SELECT. fill_req is ignored in all other states.
- SELECT (1 cycle): choose victim V.
  - V is the lowest-numbered invalid way of the set; if all ways are valid, V is the PLRU way.
  - If V is valid and dirty: arr_rd_en=1 with index/way = set/V, then go to RDWAIT.
  - Otherwise go to WRITE.
- RDWAIT (1 cycle): register arr_rd_tag/arr_rd_data into wb_tag/wb_data, set wb_index, then go to WRITEBACK.
- WRITEBACK: wb_valid=1 with wb_* stable. When wb_valid & wb_ready, go to WRITE. There is no timeout.
- WRITE (1 cycle): arr_wr_en=1, fill_ack=1, fill_way=V.
  - Set valid[set][V]=1 and dirty[set][V]=fill_dirty.
  - Apply a PLRU touch of V. Go to IDLE.
- Latency from fill_req sampled in IDLE (cycle 0): clean or invalid victim gives fill_ack in cycle 2; dirty victim gives wb_valid from cycle 3.
- PLRU: binary tree, WAYS-1 bits per set, node 0 is the root.
  - Each node bit=0 points the victim into the lower half, bit=1 into the upper half.
  - A touch of way w sets every node on w's path to point away from w.
- hit_valid touches hit_way in hit_index in any state. hit_valid never changes valid or dirty.
- Simultaneous hit touch and WRITE touch on the same set: apply the hit first, then the fill; the fill wins on shared nodes.
- A hit in SELECT to the set being filled must be visible to that cycle's victim choice: use forwarded PLRU.
- valid_out is purely combinational from stored state. A WRITE update is visible from the following cycle.

Test Plan:
- Reset, then fill set 3 eight times with tags 0x001..0x008, clean → fill_way 0..7 in order (invalid-first), fill_ack 2 cycles after each accepted request, valid_out[3]=0xFF, no wb_valid.
- Set 3 full (after the 8 fills, PLRU points to way 0); hits to ways 0,1,2,3 → next fill picks way 4; repeat with hits to 4..7 → victim way 0.
- Dirty victim: fill set 5 way 0 with fill_dirty=1, tag 0x155, data 0x1AA, then fill set 5 ways 1..7 clean (8 fills total, PLRU points to way 0); fill 0x2AB → arr_rd_en for set 5 way 0, wb_valid with wb_tag=0x155, wb_data=0x1AA; hold wb_ready=0 for 4 cycles → wb_* stable, no write; assert wb_ready → arr_wr_en the next cycle, way 0, tag 0x2AB, fill_ack.
- hit_valid to (set 5, way 4) in the same cycle as WRITE to set 5 way 0 → final PLRU equals "touch 4 then touch 0"; check the next victim.
- Assert reset during WRITEBACK → wb_valid=0 next cycle, no arr_wr_en, valid_out=0 for all sets.
- Hold fill_req high through ack and deassert one cycle later → exactly one extra fill accepted (request re-sampled in IDLE); verify the bench protocol drops fill_req on fill_ack.
